// File: rtl/klp32_mem_pkg.sv
// Shared definitions for the klp32 data-memory path: access-mode encodings,
// LSU state encoding and the access-size helper.
package klp32_mem_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] MODE_BYTE    = 2'b00;
  localparam logic [1:0] MODE_HALF    = 2'b01;
  localparam logic [1:0] MODE_WORD    = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;
  localparam int         MODE_UNSIGNED = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      MODE_BYTE: size_bytes = 3'd1;
      MODE_HALF: size_bytes = 3'd2;
      MODE_WORD: size_bytes = 3'd4;
      default:   size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load extension: sign- or zero-extends an assembled byte or
// halfword to the full data width; words pass through unchanged.
module lsu_load_extend
  import klp32_mem_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = data;
    case (size)
      MODE_BYTE: result = {{(DATA_W-8){~is_unsigned & data[7]}}, data[7:0]};
      MODE_HALF: result = {{(DATA_W-16){~is_unsigned & data[15]}}, data[15:0]};
      default:   result = data;
    endcase
  end

endmodule

// File: rtl/load_store_unit32.sv
// Big-endian load/store unit: one request at a time, misaligned accesses split
// into byte beats. Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word.
module load_store_unit32
  import klp32_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_mode,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  output logic [2:0]        mem_loadStoreMode,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_t        state, state_nxt;
  logic [DATA_W-1:0] addr_p0, wdata_p0, acc_p0, assembled, extended;
  logic [1:0]        size_p0, beat_p0, beat_nxt;
  logic              uns_p0, write_p0, split_p0, err_p0;
  logic              accept, misaligned, reject, last_beat;

  // Store byte for a split beat: the most significant byte goes out first.
  function automatic logic [7:0] beat_byte(input logic [DATA_W-1:0] w,
                                           input logic [1:0] size,
                                           input logic [1:0] beat);
    logic [1:0] idx;
    idx = 2'(size_bytes(size) - 3'd1) - beat;
    return w[{idx, 3'b000} +: 8];
  endfunction

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign accept     = req_valid && req_ready;
  assign misaligned = ((req_mode[1:0] == MODE_HALF) && req_addr[0]) ||
                      ((req_mode[1:0] == MODE_WORD) && (req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
  assign reject = (req_mode[1:0] == MODE_ILLEGAL) || misaligned;
`else
  assign reject = (req_mode[1:0] == MODE_ILLEGAL);
`endif

  // Rejected requests spend one ACCESS cycle with the strobe suppressed so every
  // response arrives no sooner than the aligned latency. A reset in ACCESS
  // must not commit the beat in flight, hence the rst term.
  assign mem_write_enable = write_p0 && !err_p0 && (state == ST_ACCESS) && !rst;
  assign last_beat = err_p0 || !split_p0 || ({1'b0, beat_p0} == size_bytes(size_p0) - 3'd1);
  assign beat_nxt  = beat_p0 + 2'd1;
  assign assembled = split_p0 ? {acc_p0[DATA_W-9:0], mem_read_data[7:0]} : mem_read_data;

  lsu_load_extend u_extend (
    .data        (assembled),
    .size        (size_p0),
    .is_unsigned (uns_p0),
    .result      (extended)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept)     state_nxt = ST_ACCESS;
      ST_ACCESS: if (last_beat)  state_nxt = ST_RESP;
      ST_RESP:   if (resp_ready) state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  // p0: latched request and beat progress
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      size_p0  <= req_mode[1:0];
      uns_p0   <= req_mode[MODE_UNSIGNED];
      write_p0 <= req_write;
      split_p0 <= misaligned && !reject;
      err_p0   <= reject;
      beat_p0  <= 2'd0;
      acc_p0   <= '0;
    end else if (state == ST_ACCESS) begin
      beat_p0 <= beat_nxt;
      acc_p0  <= assembled;
    end
  end

  // Memory port drive and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr          <= '0;
      mem_write_data    <= '0;
      mem_loadStoreMode <= '0;
      resp_rdata        <= '0;
      resp_err          <= 1'b0;
    end else if (accept) begin
      if (!reject) begin
        mem_addr          <= req_addr;
        mem_loadStoreMode <= {~req_write, misaligned ? MODE_BYTE : req_mode[1:0]};
        mem_write_data    <= misaligned ?
                             {{(DATA_W-8){1'b0}}, beat_byte(req_wdata, req_mode[1:0], 2'd0)} :
                             req_wdata;
      end
    end else if (state == ST_ACCESS) begin
      if (last_beat) begin
        resp_err   <= err_p0;
        resp_rdata <= (write_p0 || err_p0) ? '0 : extended;
      end else begin
        mem_addr       <= addr_p0 + DATA_W'(beat_nxt);
        mem_write_data <= {{(DATA_W-8){1'b0}}, beat_byte(wdata_p0, size_p0, beat_nxt)};
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit32.sv
// Directed bench for load_store_unit32 with a big-endian byte memory model;
// expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_load_store_unit32;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_mode = '0;
  logic        req_ready, resp_valid, resp_err, mem_write_enable;
  logic [31:0] resp_rdata, mem_addr, mem_write_data, mem_read_data;
  logic [2:0]  mem_loadStoreMode;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit32 dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_mode          (req_mode),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_rdata        (resp_rdata),
    .resp_err          (resp_err),
    .mem_addr          (mem_addr),
    .mem_write_data    (mem_write_data),
    .mem_write_enable  (mem_write_enable),
    .mem_loadStoreMode (mem_loadStoreMode),
    .mem_read_data     (mem_read_data)
  );

  // Big-endian byte memory, combinational read (zero-extending), synchronous write
  logic [7:0] mem [0:1023] = '{default: 8'h00};
  logic [9:0] i0, i1, i2, i3;
  assign i0 = mem_addr[9:0];
  assign i1 = i0 + 10'd1;
  assign i2 = i0 + 10'd2;
  assign i3 = i0 + 10'd3;

  always_comb begin
    mem_read_data = 32'h0;
    case (mem_loadStoreMode[1:0])
      2'b00:   mem_read_data = {24'h0, mem[i0]};
      2'b01:   mem_read_data = {16'h0, mem[i0], mem[i1]};
      2'b10:   mem_read_data = {mem[i0], mem[i1], mem[i2], mem[i3]};
      default: mem_read_data = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write_enable) begin
      case (mem_loadStoreMode[1:0])
        2'b00: mem[i0] <= mem_write_data[7:0];
        2'b01: begin
          mem[i0] <= mem_write_data[15:8];
          mem[i1] <= mem_write_data[7:0];
        end
        2'b10: begin
          mem[i0] <= mem_write_data[31:24];
          mem[i1] <= mem_write_data[23:16];
          mem[i2] <= mem_write_data[15:8];
          mem[i3] <= mem_write_data[7:0];
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  logic [31:0] beat_addr [0:7];
  logic [2:0]  beat_mode [0:7];
  int          nbeats;

  task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] m, output logic [31:0] rd, output logic er,
                         output int lat, output logic we_seen);
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = wd; req_mode = m; req_valid = 1'b1;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; we_seen = 1'b0; nbeats = 0;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      we_seen |= mem_write_enable;
      if (nbeats < 8) begin
        beat_addr[nbeats] = mem_addr;
        beat_mode[nbeats] = mem_loadStoreMode;
      end
      nbeats++;
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata; er = resp_err;
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("handshake_clear", {30'b0, resp_valid, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  m;
    logic [31:0] er;
    logic        ee;
    int          lat;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  initial begin
    logic [31:0] rd;
    logic        er, we;
    int          lat;

    vecs[0]  = '{1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 1};
    vecs[1]  = '{1'b0, 32'h100, 32'h0, 3'b110, 32'hDEADBEEF, 1'b0, 1};
    vecs[2]  = '{1'b0, 32'h100, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0, 1};
    vecs[3]  = '{1'b0, 32'h100, 32'h0, 3'b100, 32'h000000DE, 1'b0, 1};
    vecs[4]  = '{1'b0, 32'h102, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0, 1};
    vecs[5]  = '{1'b0, 32'h102, 32'h0, 3'b101, 32'h0000BEEF, 1'b0, 1};
    vecs[6]  = '{1'b1, 32'h104, 32'h12, 3'b000, 32'h0, 1'b0, 1};
    vecs[7]  = '{1'b0, 32'h101, 32'h0, 3'b010, TRAP ? 32'h0 : 32'hADBEEF12, TRAP, TRAP ? 1 : 4};
    vecs[8]  = '{1'b0, 32'h101, 32'h0, 3'b001, TRAP ? 32'h0 : 32'hFFFFADBE, TRAP, TRAP ? 1 : 2};
    vecs[9]  = '{1'b0, 32'h103, 32'h0, 3'b101, TRAP ? 32'h0 : 32'h0000EF12, TRAP, TRAP ? 1 : 2};
    vecs[10] = '{1'b0, 32'h100, 32'h0, 3'b011, 32'h0, 1'b1, 1};
    vecs[11] = '{1'b1, 32'h100, 32'hFFFFFFFF, 3'b111, 32'h0, 1'b1, 1};
    vecs[12] = '{1'b0, 32'h100, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 1};
    vecs[13] = '{1'b1, 32'hFFFFFFFE, 32'h11223344, 3'b010, 32'h0, TRAP, TRAP ? 1 : 4};
    vecs[14] = '{1'b0, 32'hFFFFFFFE, 32'h0, 3'b110, TRAP ? 32'h0 : 32'h11223344, TRAP, TRAP ? 1 : 4};
    vecs[15] = '{1'b0, 32'h0, 32'h0, 3'b100, TRAP ? 32'h0 : 32'h33, 1'b0, 1};
    vecs[16] = '{1'b0, 32'hFFFFFFFF, 32'h0, 3'b000, TRAP ? 32'h0 : 32'h22, 1'b0, 1};
    vecs[17] = '{1'b1, 32'h301, 32'h5A6B, 3'b001, 32'h0, TRAP, TRAP ? 1 : 2};
    vecs[18] = '{1'b0, 32'h302, 32'h0, 3'b000, TRAP ? 32'h0 : 32'h6B, 1'b0, 1};
    vecs[19] = '{1'b0, 32'h301, 32'h0, 3'b000, TRAP ? 32'h0 : 32'h5A, 1'b0, 1};
    vecs[20] = '{1'b1, 32'h200, 32'h8001, 3'b001, 32'h0, 1'b0, 1};
    vecs[21] = '{1'b0, 32'h200, 32'h0, 3'b001, 32'hFFFF8001, 1'b0, 1};
    vecs[22] = '{1'b0, 32'h200, 32'h0, 3'b101, 32'h00008001, 1'b0, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_we", {31'b0, mem_write_enable}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    chk("rst_mem_mode", {29'b0, mem_loadStoreMode}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      run_req(vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].m, rd, er, lat, we);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].er);
      chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].ee});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_write_strobe", i), {31'b0, we}, {31'b0, vecs[i].w & ~vecs[i].ee});
    end

    chk("mem_be_100", {mem[256], mem[257], mem[258], mem[259]}, 32'hDEADBEEF);

`ifndef LSU_MISALIGN_TRAP_EN
    // Misaligned word: byte beats at consecutive addresses
    run_req(1'b0, 32'h101, 32'h0, 3'b010, rd, er, lat, we);
    chk("split_beats", nbeats, 4);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("split_beat%0d_addr", b), beat_addr[b], 32'h101 + b);
      chk($sformatf("split_beat%0d_mode", b), {29'b0, beat_mode[b]}, 32'd4);
    end

    // Reset in the middle of a split store
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h201; req_wdata = 32'hA1B2C3D4; req_mode = 3'b010;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_we", {31'b0, mem_write_enable}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_resp", {31'b0, resp_valid}, 32'd0);
    chk("rst_mid_mem", {mem[10'h201], mem[10'h202], mem[10'h203], mem[10'h204]}, 32'hA1B2_0000);
`endif

    // Response backpressure; a request offered meanwhile must be ignored
    @(negedge clk);
    req_write = 1'b0; req_addr = 32'h100; req_wdata = 32'h0; req_mode = 3'b010;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_write = 1'b1; req_wdata = 32'h77; req_mode = 3'b000;
    @(posedge clk); #1;
    chk("bp_first_valid", {31'b0, resp_valid}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_valid", c), {31'b0, resp_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_rdata", c), resp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp_hold%0d_req_ready", c), {31'b0, req_ready}, 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp_release", {30'b0, resp_valid, req_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_ghost_resp", {31'b0, resp_valid}, 32'd0);
    chk("bp_no_ghost_write", {24'b0, mem[10'h100]}, 32'hDE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
